lat_cfg_sequencer: RTL and testbench

// - Loads the look-at-table FSM configuration: accepts one 27-bit config word (clock-select + five 5-bit jump targets) over valid/ready, shifts it serially onto the SIPO REG_STATE line, then releases the state machine.
// - Sits between the host/config source and the table-FSM top; sole driver of REG_STATE and of the FSM run gate.
// - Watches the SIPO 'finished' flag; flags an error if the flag does not arrive in time.

---
 rtl/lat_pkg.sv | 36 +++
 rtl/lat_cfg_sequencer_if.sv | 11 +
 rtl/lat_piso_shift.sv | 39 +++
 rtl/lat_cfg_sequencer.sv | 110 +++++++++++
 tb/tb_lat_cfg_sequencer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/lat_pkg.sv
// Shared constants for the look-at-table config sequencer: word layout, widths and
// state encodings.
package lat_pkg;

   localparam int unsigned CFG_W    = 27;
   localparam int unsigned JUMP_W   = 5;
   localparam int unsigned N_JUMPS  = 5;
   localparam int unsigned CLKSEL_W = 2;

   // Config word layout: clk_sel on top, jump1..jump5 descending below it
   localparam int unsigned CLKSEL_LSB = CFG_W - CLKSEL_W;
   localparam int unsigned JUMP1_LSB  = 20;
   localparam int unsigned JUMP2_LSB  = 15;
   localparam int unsigned JUMP3_LSB  = 10;
   localparam int unsigned JUMP4_LSB  = 5;
   localparam int unsigned JUMP5_LSB  = 0;

   typedef logic [2:0] lat_state_t;

   localparam lat_state_t StIdle   = 3'd0;
   localparam lat_state_t StClr    = 3'd1;
   localparam lat_state_t StShift  = 3'd2;
   localparam lat_state_t StWait   = 3'd3;
   localparam lat_state_t StSettle = 3'd4;
   localparam lat_state_t StRun    = 3'd5;

   function automatic logic [CFG_W-1:0] cfg_pack(input logic [CLKSEL_W-1:0] clk_sel,
                                                 input logic [JUMP_W-1:0]   jump1,
                                                 input logic [JUMP_W-1:0]   jump2,
                                                 input logic [JUMP_W-1:0]   jump3,
                                                 input logic [JUMP_W-1:0]   jump4,
                                                 input logic [JUMP_W-1:0]   jump5);
      return {clk_sel, jump1, jump2, jump3, jump4, jump5};
   endfunction

endpackage

// File: rtl/lat_cfg_sequencer_if.sv
// Config word valid/ready channel between the host and the sequencer.
interface lat_cfg_sequencer_if;

   logic [lat_pkg::CFG_W-1:0] cfg_word;
   logic                      cfg_valid;
   logic                      cfg_ready;

   modport master (output cfg_word, output cfg_valid, input cfg_ready);
   modport slave  (input cfg_word, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/lat_piso_shift.sv
// Parallel-load, MSB-first shift register with a bit down-counter; 'last' marks the
// cycle in which bit 0 is presented.
module lat_piso_shift #(
   parameter int unsigned Width = 27
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             load,
   input  logic [Width-1:0] load_data,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             last
);

   localparam int unsigned CntW = $clog2(Width);

   logic [Width-1:0] sr_q;
   logic [CntW-1:0]  cnt_q;

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else if (load) begin
         sr_q  <= load_data;
         cnt_q <= CntW'(Width - 1);
      end else if (shift_en) begin
         sr_q <= {sr_q[Width-2:0], 1'b0};
         // Saturate at zero so the counter never wraps past bit 0
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign ser_out = sr_q[Width-1];
   assign last    = (cnt_q == '0);

endmodule

// File: rtl/lat_cfg_sequencer.sv
// Accepts one table-FSM config word, shifts it MSB-first onto the SIPO line, waits for
// the SIPO 'finished' flag, settles, then releases the table FSM.
module lat_cfg_sequencer
   import lat_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 2,
   parameter int unsigned TMO_CYC    = 8
) (
   input  logic                clk_in,
   input  logic                reset,
   lat_cfg_sequencer_if.slave  cfg,
   output logic                ser_data,
   output logic                ser_en,
   output logic                sipo_rst_n,
   input  logic                sipo_finished,
   output logic                fsm_run,
   output logic                busy,
   output logic                err
);

   lat_state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic       rst_q;
   logic       accept;
   logic       shift_en;
   logic       piso_bit;
   logic       piso_last;

   assign accept   = cfg.cfg_valid & cfg.cfg_ready;
   assign shift_en = (state_q == StShift);

   lat_piso_shift #(
      .Width (CFG_W)
   ) u_piso (
      .clk_in    (clk_in),
      .reset     (reset),
      .load      (accept),
      .load_data (cfg.cfg_word),
      .shift_en  (shift_en),
      .ser_out   (piso_bit),
      .last      (piso_last)
   );

   // cnt_q is shared: timeout count in WAIT, settle count in SETTLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         StIdle, StRun: begin
            if (accept) begin
               err_d   = 1'b0;
               state_d = StClr;
            end
         end
         StClr: state_d = StShift;
         StShift: begin
            if (piso_last) begin
               cnt_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            if (sipo_finished) begin
               cnt_d   = '0;
               state_d = StSettle;
            end else if (cnt_q == 8'(TMO_CYC - 1)) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StSettle: begin
            if (cnt_q == 8'(SETTLE_CYC - 1)) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         rst_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         rst_q   <= 1'b0;
      end
   end

   // rst_q holds the SIPO in clear for the cycle following any reset edge
   assign cfg.cfg_ready = (state_q == StIdle) || (state_q == StRun);
   assign ser_en        = shift_en;
   assign ser_data      = shift_en & piso_bit;
   assign sipo_rst_n    = !rst_q && (state_q != StClr);
   assign fsm_run       = (state_q == StRun);
   assign busy          = (state_q == StClr) || (state_q == StShift) ||
                          (state_q == StWait) || (state_q == StSettle);
   assign err           = err_q;

endmodule

// File: tb/tb_lat_cfg_sequencer.sv
// Directed bench for lat_cfg_sequencer: load, reload, held word, timeout, stale-flag
// glitch and mid-load reset.
module tb_lat_cfg_sequencer;
   import lat_pkg::*;

   logic clk_in = 1'b0;
   logic reset;
   logic ser_data, ser_en, sipo_rst_n, sipo_finished, fsm_run, busy, err;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   lat_cfg_sequencer_if cfg_bus ();

   always #5 clk_in = ~clk_in;

   lat_cfg_sequencer #(
      .SETTLE_CYC (2),
      .TMO_CYC    (8)
   ) dut (
      .clk_in        (clk_in),
      .reset         (reset),
      .cfg           (cfg_bus),
      .ser_data      (ser_data),
      .ser_en        (ser_en),
      .sipo_rst_n    (sipo_rst_n),
      .sipo_finished (sipo_finished),
      .fsm_run       (fsm_run),
      .busy          (busy),
      .err           (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, 32'(cfg_bus.cfg_ready), 32'd1);
      check_eq({tag, "_ser_data"}, 32'(ser_data), 32'd0);
      check_eq({tag, "_ser_en"}, 32'(ser_en), 32'd0);
      check_eq({tag, "_sipo_rst_n"}, 32'(sipo_rst_n), 32'd0);
      check_eq({tag, "_fsm_run"}, 32'(fsm_run), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_err"}, 32'(err), 32'd0);
   endtask

   // Starts from IDLE or RUN; finish=1 raises sipo_finished on the first WAIT cycle,
   // otherwise WAIT times out. glitch_bit raises sipo_finished during that SHIFT bit.
   task automatic run_load(input logic [CFG_W-1:0] w, input bit finish, input int glitch_bit,
                           input bit hold, input logic [CFG_W-1:0] hold_w, input string tag);
      logic [CFG_W-1:0] stream;
      int               en_cnt;
      stream = '0;
      en_cnt = 0;
      check_eq({tag, "_ready_pre"}, 32'(cfg_bus.cfg_ready), 32'd1);
      cfg_bus.cfg_word  = w;
      cfg_bus.cfg_valid = 1'b1;
      step();
      if (hold) cfg_bus.cfg_word = hold_w;
      else cfg_bus.cfg_valid = 1'b0;
      check_eq({tag, "_clr_sipo_rst_n"}, 32'(sipo_rst_n), 32'd0);
      check_eq({tag, "_clr_ser_en"}, 32'(ser_en), 32'd0);
      check_eq({tag, "_clr_fsm_run"}, 32'(fsm_run), 32'd0);
      check_eq({tag, "_clr_busy"}, 32'(busy), 32'd1);
      check_eq({tag, "_clr_ready"}, 32'(cfg_bus.cfg_ready), 32'd0);
      check_eq({tag, "_clr_err"}, 32'(err), 32'd0);
      for (int i = CFG_W - 1; i >= 0; i--) begin
         step();
         stream[i] = ser_data;
         if (ser_en) en_cnt++;
         sipo_finished = (i == glitch_bit);
      end
      check_eq({tag, "_stream"}, 32'(stream), 32'(w));
      check_eq({tag, "_ser_en_cycles"}, 32'(en_cnt), 32'(CFG_W));
      check_eq({tag, "_shift_ready"}, 32'(cfg_bus.cfg_ready), 32'd0);
      check_eq({tag, "_shift_sipo_rst_n"}, 32'(sipo_rst_n), 32'd1);
      sipo_finished = 1'b0;
      step();
      check_eq({tag, "_wait_ser_en"}, 32'(ser_en), 32'd0);
      check_eq({tag, "_wait_busy"}, 32'(busy), 32'd1);
      if (finish) begin
         sipo_finished = 1'b1;
         step();
         sipo_finished = 1'b0;
         check_eq({tag, "_settle0_fsm_run"}, 32'(fsm_run), 32'd0);
         check_eq({tag, "_settle0_busy"}, 32'(busy), 32'd1);
         step();
         check_eq({tag, "_settle1_fsm_run"}, 32'(fsm_run), 32'd0);
         step();
         check_eq({tag, "_run_fsm_run"}, 32'(fsm_run), 32'd1);
         check_eq({tag, "_run_busy"}, 32'(busy), 32'd0);
         check_eq({tag, "_run_ready"}, 32'(cfg_bus.cfg_ready), 32'd1);
         check_eq({tag, "_run_err"}, 32'(err), 32'd0);
      end else begin
         for (int k = 0; k < 7; k++) step();
         check_eq({tag, "_tmo_early_err"}, 32'(err), 32'd0);
         check_eq({tag, "_tmo_early_busy"}, 32'(busy), 32'd1);
         step();
         check_eq({tag, "_tmo_err"}, 32'(err), 32'd1);
         check_eq({tag, "_tmo_busy"}, 32'(busy), 32'd0);
         check_eq({tag, "_tmo_fsm_run"}, 32'(fsm_run), 32'd0);
         check_eq({tag, "_tmo_ready"}, 32'(cfg_bus.cfg_ready), 32'd1);
         step();
         check_eq({tag, "_idle_err_sticky"}, 32'(err), 32'd1);
      end
   endtask

   initial begin
      logic [CFG_W-1:0] w_rst;
      w_rst             = 27'h1234567;
      reset             = 1'b0;
      sipo_finished     = 1'b0;
      cfg_bus.cfg_word  = '0;
      cfg_bus.cfg_valid = 1'b0;
      step();
      step();
      check_reset_outputs("reset");
      reset = 1'b1;
      step();
      check_eq("idle_sipo_rst_n", 32'(sipo_rst_n), 32'd1);
      check_eq("idle_busy", 32'(busy), 32'd0);

      run_load(27'h5A5A5A5, 1'b1, -1, 1'b0, '0, "load1");
      // Reload from RUN while holding a different word across the whole load
      run_load(cfg_pack(2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5), 1'b1, -1, 1'b1, 27'h3C59A71,
               "reload_hold");
      run_load(27'h3C59A71, 1'b1, -1, 1'b0, '0, "held");
      run_load(27'h7FFFFFF, 1'b0, -1, 1'b0, '0, "tmo");
      run_load(27'h0000001, 1'b0, 0, 1'b0, '0, "glitch");
      run_load(27'h5A5A5A5, 1'b1, -1, 1'b0, '0, "after_err");

      cfg_bus.cfg_word  = w_rst;
      cfg_bus.cfg_valid = 1'b1;
      step();
      cfg_bus.cfg_valid = 1'b0;
      for (int k = 0; k < 14; k++) step();
      check_eq("midrst_bit13_en", 32'(ser_en), 32'd1);
      check_eq("midrst_bit13_data", 32'(ser_data), 32'(w_rst[13]));
      reset = 1'b0;
      step();
      check_reset_outputs("midrst");
      reset = 1'b1;
      step();
      check_eq("midrst_release_fsm_run", 32'(fsm_run), 32'd0);
      run_load(27'h6DB6DB6, 1'b1, -1, 1'b0, '0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
